// File: rtl/rx_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// rx_ctrl_pkg
// Shared definitions for the RX moving-sum sequencer:
//   - state_e    : sequencer state encoding
//   - cmp_tag_t  : compare tag carried alongside each sample in the pipeline
//   - DW_DEF / SW_DEF : default sample and sum widths
//   - sum_above  : signed strict greater-than used for the threshold compare
// ---------------------------------------------------------------------------
package rx_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_RUN    = 2'd2,
        ST_DETECT = 2'd3
    } state_e;

    localparam int DW_DEF = 17;
    localparam int SW_DEF = 24;

    // Wide enough for any sum width the sequencer is built with; callers
    // sign-extend into it so one helper serves every SW.
    localparam int CMP_W = 64;

    typedef struct packed {
        logic        tag;   // sample takes part in a threshold compare
        logic [15:0] idx;   // sample index reported on detect
    } cmp_tag_t;

    function automatic logic sum_above(input logic signed [CMP_W-1:0] sum,
                                       input logic signed [CMP_W-1:0] thr);
        return sum > thr;
    endfunction

endpackage

// File: rtl/win_delay_line.sv
// ---------------------------------------------------------------------------
// win_delay_line
// WIN-deep sample delay line. Every write returns (one cycle later) the entry
// that was stored at the write pointer before it is overwritten, i.e. the
// sample written WIN writes earlier. The pointer wraps modulo WIN.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous reset, active-low (pointer and read register)
//   wr_en_i   in   write strobe
//   wr_dat_i  in   sample to store
//   rd_dat_o  out  registered old entry at the write pointer
// ---------------------------------------------------------------------------
module win_delay_line
    import rx_ctrl_pkg::*;
#(
    parameter int WIN = 16,
    parameter int DW  = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic [DW-1:0] wr_dat_i,
    output logic [DW-1:0] rd_dat_o
);

    localparam int AW = $clog2(WIN);

    logic [DW-1:0] mem [WIN];
    logic [AW-1:0] wptr_q;
    logic [DW-1:0] rd_dat_q;

    // Storage has no reset so it maps onto block RAM; stale contents are
    // masked by the fill logic in the sequencer.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wptr_q] <= wr_dat_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr_q   <= '0;
            rd_dat_q <= '0;
        end else if (wr_en_i) begin
            rd_dat_q <= mem[wptr_q];          // read-before-write
            wptr_q   <= wptr_q + 1'b1;        // WIN is a power of 2: natural wrap
        end
    end

    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/mov_sum_ctrl.sv
// ---------------------------------------------------------------------------
// mov_sum_ctrl
// Sequencer for the RX moving-sum accumulator used in packet detection.
// Feeds the accumulator new/oldest samples, tracks window fill, qualifies the
// returned sum against a threshold over HOLD consecutive compares and reports
// the detecting sample index.
// Ports:
//   clk, rst         clock, synchronous active-low reset
//   start / stop     begin (or restart) a search / abort to IDLE (stop wins)
//   in_stb, in_dat   input sample strobe and unsigned sample
//   thr              signed threshold, latched on start
//   acc_sum          signed running sum returned by the accumulator
//   acc_clr          accumulator clear (one-cycle pulse on entering FILL/IDLE)
//   acc_ena          accumulator enable
//   acc_a, acc_a_d   newest sample, sample leaving the window (0 during fill)
//   busy, full       in FILL/RUN, window filled
//   det, det_idx     held detection flag and index of the detecting sample
// ---------------------------------------------------------------------------
module mov_sum_ctrl
    import rx_ctrl_pkg::*;
#(
    parameter int WIN  = 16,
    parameter int DW   = DW_DEF,
    parameter int SW   = SW_DEF,
    parameter int HOLD = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          in_stb,
    input  logic [DW-1:0] in_dat,
    input  logic [SW-1:0] thr,
    input  logic [SW-1:0] acc_sum,
    output logic          acc_clr,
    output logic          acc_ena,
    output logic [DW-1:0] acc_a,
    output logic [DW-1:0] acc_a_d,
    output logic          busy,
    output logic          full,
    output logic          det,
    output logic [15:0]   det_idx
);

    // Sample reaches the compare two cycles after acceptance: one cycle to
    // present it to the accumulator, one for the accumulator to add it.
    localparam int              PIPE      = 2;
    localparam int              HW        = $clog2(HOLD + 1);
    localparam logic [HW-1:0]   HOLD_CNT  = HW'(HOLD);
    localparam logic [15:0]     LAST_FILL = 16'(WIN - 1);

    state_e        state_q;
    logic          acc_clr_q;
    logic          acc_ena_q;
    logic          ad_vld_q;
    logic          full_q;
    logic          det_q;
    logic [DW-1:0] acc_a_q;
    logic [15:0]   idx_q;
    logic [15:0]   det_idx_q;
    logic [SW-1:0] thr_q;
    logic [HW-1:0] hit_q;
    logic [HW-1:0] hit_d;

    logic          active;
    logic          flush;
    logic          accept;
    logic          is_cmp;
    logic          above;
    logic          det_hit;
    logic [15:0]   idx_inc;
    logic [DW-1:0] rd_dat;

    cmp_tag_t      pipe_in;
    cmp_tag_t      pipe_q [PIPE];

    assign active  = (state_q == ST_FILL) || (state_q == ST_RUN);
    assign flush   = start || stop;
    // Samples are dropped while the accumulator is being cleared and in the
    // cycle a start/stop restarts the search.
    assign accept  = active && in_stb && !acc_clr_q && !flush;
    assign idx_inc = (idx_q == 16'hFFFF) ? idx_q : idx_q + 16'd1;

    assign pipe_in.tag = accept && (idx_q >= LAST_FILL);
    assign pipe_in.idx = idx_q;

    // Compare-tag pipeline, flushed on start/stop so in-flight samples of an
    // abandoned search never reach the detector.
    generate
        for (genvar gi = 0; gi < PIPE; gi++) begin : g_cmp_pipe
            cmp_tag_t src;
            if (gi == 0) begin : g_head
                assign src = pipe_in;
            end else begin : g_body
                assign src = pipe_q[gi-1];
            end
            always_ff @(posedge clk) begin
                if (!rst || flush) begin
                    pipe_q[gi] <= '0;
                end else begin
                    pipe_q[gi] <= src;
                end
            end
        end
    endgenerate

    assign is_cmp  = pipe_q[PIPE-1].tag && (state_q == ST_RUN);
    assign above   = sum_above(CMP_W'($signed(acc_sum)), CMP_W'($signed(thr_q)));

    always_comb begin
        hit_d = hit_q;
        if (is_cmp) begin
            if (!above) begin
                hit_d = '0;
            end else if (hit_q != HOLD_CNT) begin
                hit_d = hit_q + 1'b1;
            end
        end
    end

    assign det_hit = is_cmp && above && (hit_d == HOLD_CNT);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            acc_clr_q <= 1'b1;
            acc_ena_q <= 1'b0;
            ad_vld_q  <= 1'b0;
            acc_a_q   <= '0;
            full_q    <= 1'b0;
            det_q     <= 1'b0;
            det_idx_q <= '0;
            idx_q     <= '0;
            hit_q     <= '0;
            thr_q     <= '0;
        end else begin
            acc_clr_q <= 1'b0;
            acc_ena_q <= accept;
            // Oldest sample only exists once the window has been filled.
            ad_vld_q  <= accept && (state_q == ST_RUN);
            hit_q     <= hit_d;
            if (accept) begin
                acc_a_q <= in_dat;
                idx_q   <= idx_inc;
            end

            case (state_q)
                ST_FILL: begin
                    // During FILL the sample index doubles as the fill count.
                    if (accept && (idx_q == LAST_FILL)) begin
                        state_q <= ST_RUN;
                        full_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (det_hit) begin
                        state_q   <= ST_DETECT;
                        det_q     <= 1'b1;
                        det_idx_q <= pipe_q[PIPE-1].idx;
                    end
                end
                default: ;
            endcase

            if (flush) begin
                acc_clr_q <= start || (state_q != ST_IDLE);
                state_q   <= stop ? ST_IDLE : ST_FILL;
                idx_q     <= '0;
                hit_q     <= '0;
                full_q    <= 1'b0;
                det_q     <= 1'b0;
                det_idx_q <= '0;
                if (!stop) begin
                    thr_q <= thr;
                end
            end
        end
    end

    win_delay_line #(
        .WIN (WIN),
        .DW  (DW)
    ) u_win_delay_line (
        .clk      (clk),
        .rst      (rst),
        .wr_en_i  (accept),
        .wr_dat_i (in_dat),
        .rd_dat_o (rd_dat)
    );

    assign acc_clr = acc_clr_q;
    assign acc_ena = acc_ena_q;
    assign acc_a   = acc_a_q;
    assign acc_a_d = ad_vld_q ? rd_dat : '0;
    assign busy    = active;
    assign full    = full_q;
    assign det     = det_q;
    assign det_idx = det_idx_q;

endmodule

// File: tb/tb_mov_sum_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mov_sum_ctrl
// Drives mov_sum_ctrl with directed and random sample streams, closes the
// loop with a behavioural accumulator, and checks every output against
// window sums and detect indices computed directly from the sample array.
// ---------------------------------------------------------------------------
module tb_mov_sum_ctrl;

    localparam int WIN  = 16;
    localparam int DW   = 17;
    localparam int SW   = 24;
    localparam int HOLD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          stop = 1'b0;
    logic          in_stb = 1'b0;
    logic [DW-1:0] in_dat = '0;
    logic [SW-1:0] thr = '0;
    logic [SW-1:0] acc_sum;
    logic          acc_clr;
    logic          acc_ena;
    logic [DW-1:0] acc_a;
    logic [DW-1:0] acc_a_d;
    logic          busy;
    logic          full;
    logic          det;
    logic [15:0]   det_idx;

    int total = 0;
    int bad   = 0;
    int smp [0:127];

    always #5 clk = ~clk;

    mov_sum_ctrl #(.WIN(WIN), .DW(DW), .SW(SW), .HOLD(HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .stop    (stop),
        .in_stb  (in_stb),
        .in_dat  (in_dat),
        .thr     (thr),
        .acc_sum (acc_sum),
        .acc_clr (acc_clr),
        .acc_ena (acc_ena),
        .acc_a   (acc_a),
        .acc_a_d (acc_a_d),
        .busy    (busy),
        .full    (full),
        .det     (det),
        .det_idx (det_idx)
    );

    // Behavioural accumulator: sum += newest - oldest.
    logic [SW-1:0] acc_model_q = '0;
    always @(posedge clk) begin
        if (!rst || acc_clr) acc_model_q <= '0;
        else if (acc_ena)    acc_model_q <= acc_model_q + SW'(acc_a) - SW'(acc_a_d);
    end
    assign acc_sum = acc_model_q;

    // Sum of the (up to WIN) samples ending at index last.
    function automatic longint wsum(input int last);
        longint s = 0;
        for (int i = last - WIN + 1; i <= last; i++) begin
            if (i >= 0) s += smp[i];
        end
        return s;
    endfunction

    // First index whose window sum is above thr for HOLD full windows in a row.
    function automatic int find_det(input int n, input int thr_v);
        int run = 0;
        for (int i = WIN - 1; i < n; i++) begin
            if (wsum(i) > longint'(thr_v)) run++;
            else run = 0;
            if (run == HOLD) return i;
        end
        return -1;
    endfunction

    task automatic do_start(input int thr_v);
        thr = SW'(thr_v); start = 1'b1; in_stb = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        total++; if (acc_clr !== 1'b1) begin bad++; $display("FAIL start_clr got=%0b want=1", acc_clr); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL start_busy got=%0b want=1", busy); end
        total++; if (det !== 1'b0) begin bad++; $display("FAIL start_det got=%0b want=0", det); end
        total++; if (det_idx !== 16'd0) begin bad++; $display("FAIL start_det_idx got=%0d want=0", det_idx); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL start_full got=%0b want=0", full); end
        // Strobe during the clear cycle must be dropped; threshold input is
        // changed afterwards to confirm the latched value is what counts.
        in_stb = 1'b1; in_dat = 17'h1ABCD; thr = 24'h7FFFFF;
        @(posedge clk); #1;
        in_stb = 1'b0;
        total++; if (acc_ena !== 1'b0) begin bad++; $display("FAIL clr_cycle_ena got=%0b want=0", acc_ena); end
        total++; if (acc_clr !== 1'b0) begin bad++; $display("FAIL clr_pulse_len got=%0b want=0", acc_clr); end
    endtask

    task automatic stream(input int nsamp, input int exp_det);
        int  last;
        bit  acc_e;
        bit  det_e;
        int  exp_ad;
        last = (exp_det >= 0) ? exp_det + 3 : nsamp - 1;
        for (int k = 0; k <= last; k++) begin
            in_stb = 1'b1; in_dat = DW'(smp[k]);
            @(posedge clk); #1;
            acc_e  = (exp_det < 0) || (k <= exp_det + 2);
            det_e  = (exp_det >= 0) && (k >= exp_det + 2);
            exp_ad = (k >= WIN) ? smp[k-WIN] : 0;
            total++; if (acc_ena !== acc_e) begin bad++; $display("FAIL ena k=%0d got=%0b want=%0b", k, acc_ena, acc_e); end
            if (acc_e) begin
                total++; if (acc_a !== DW'(smp[k])) begin bad++; $display("FAIL acc_a k=%0d got=%0d want=%0d", k, acc_a, smp[k]); end
                total++; if (acc_a_d !== DW'(exp_ad)) begin bad++; $display("FAIL acc_a_d k=%0d got=%0d want=%0d", k, acc_a_d, exp_ad); end
            end
            total++; if (acc_sum !== SW'(wsum(k - 1))) begin bad++; $display("FAIL acc_sum k=%0d got=%0d want=%0d", k, acc_sum, wsum(k - 1)); end
            total++; if (full !== (k >= WIN - 1)) begin bad++; $display("FAIL full k=%0d got=%0b want=%0b", k, full, (k >= WIN - 1)); end
            total++; if (det !== det_e) begin bad++; $display("FAIL det k=%0d got=%0b want=%0b", k, det, det_e); end
            total++; if (busy !== !det_e) begin bad++; $display("FAIL busy k=%0d got=%0b want=%0b", k, busy, !det_e); end
            if (det_e) begin
                total++; if (det_idx !== 16'(exp_det)) begin bad++; $display("FAIL det_idx k=%0d got=%0d want=%0d", k, det_idx, exp_det); end
            end
            $display("sample k=%0d in=%0d ena=%0b a_d=%0d sum=%0d full=%0b det=%0b", k, smp[k], acc_ena, acc_a_d, acc_sum, full, det);
        end
        in_stb = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (acc_clr !== 1'b1) begin bad++; $display("FAIL rst_clr got=%0b want=1", acc_clr); end
        total++; if (acc_ena !== 1'b0) begin bad++; $display("FAIL rst_ena got=%0b want=0", acc_ena); end
        total++; if (acc_a !== '0) begin bad++; $display("FAIL rst_acc_a got=%0d want=0", acc_a); end
        total++; if (acc_a_d !== '0) begin bad++; $display("FAIL rst_acc_a_d got=%0d want=0", acc_a_d); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0b want=0", busy); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL rst_full got=%0b want=0", full); end
        total++; if (det !== 1'b0) begin bad++; $display("FAIL rst_det got=%0b want=0", det); end
        total++; if (det_idx !== 16'd0) begin bad++; $display("FAIL rst_det_idx got=%0d want=0", det_idx); end
        rst = 1'b1;
        @(posedge clk); #1;
        total++; if (acc_clr !== 1'b0) begin bad++; $display("FAIL rst_release_clr got=%0b want=0", acc_clr); end
        $display("reset checked");
    endtask

    task automatic test_detect();
        int e;
        for (int i = 0; i < 128; i++) smp[i] = 100;
        e = find_det(80, 1599);
        $display("detect: thr=1599 expected det_idx=%0d", e);
        do_start(1599);
        stream(80, e);
    endtask

    task automatic test_no_detect();
        int e;
        for (int i = 0; i < 128; i++) smp[i] = 100;
        e = find_det(40, 1600);
        $display("no_detect: thr=1600 expected det_idx=%0d", e);
        do_start(1600);
        stream(40, e);
    endtask

    task automatic test_hit_qual();
        int e;
        for (int i = 0; i < 128; i++) smp[i] = 100;
        smp[16] = 0;
        e = find_det(80, 1599);
        $display("hit_qual: zero at 16 expected det_idx=%0d", e);
        do_start(1599);
        stream(80, e);
    endtask

    task automatic test_start_in_detect();
        for (int i = 0; i < 128; i++) smp[i] = 100;
        do_start(1599);
        stream(80, find_det(80, 1599));
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        total++; if (det !== 1'b0) begin bad++; $display("FAIL restart_det got=%0b want=0", det); end
        total++; if (det_idx !== 16'd0) begin bad++; $display("FAIL restart_det_idx got=%0d want=0", det_idx); end
        total++; if (acc_clr !== 1'b1) begin bad++; $display("FAIL restart_clr got=%0b want=1", acc_clr); end
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL restart_busy got=%0b want=1", busy); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL restart_full got=%0b want=0", full); end
        @(posedge clk); #1;
        total++; if (acc_clr !== 1'b0) begin bad++; $display("FAIL restart_clr_len got=%0b want=0", acc_clr); end
        $display("start in DETECT checked");
    endtask

    task automatic test_abort();
        for (int i = 0; i < 128; i++) smp[i] = 100;
        do_start(8388607);
        stream(10, -1);
        stop = 1'b1; in_stb = 1'b1; in_dat = 17'd55;
        @(posedge clk); #1;
        stop = 1'b0;
        total++; if (acc_clr !== 1'b1) begin bad++; $display("FAIL abort_clr got=%0b want=1", acc_clr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%0b want=0", busy); end
        total++; if (acc_ena !== 1'b0) begin bad++; $display("FAIL abort_ena got=%0b want=0", acc_ena); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            total++; if (acc_ena !== 1'b0) begin bad++; $display("FAIL idle_ena c=%0d got=%0b want=0", c, acc_ena); end
            total++; if (acc_clr !== 1'b0) begin bad++; $display("FAIL idle_clr c=%0d got=%0b want=0", c, acc_clr); end
        end
        in_stb = 1'b0;
        $display("abort checked, restarting with new data");
        for (int i = 0; i < 128; i++) smp[i] = int'($urandom_range(0, 500));
        do_start(8388607);
        stream(24, find_det(24, 8388607));
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 128; i++) smp[i] = 100;
        do_start(1599);
        stream(20, -1);
        rst = 1'b0; in_stb = 1'b1; in_dat = 17'd5;
        @(posedge clk); #1;
        total++; if (acc_clr !== 1'b1) begin bad++; $display("FAIL mrst_clr got=%0b want=1", acc_clr); end
        total++; if (acc_ena !== 1'b0) begin bad++; $display("FAIL mrst_ena got=%0b want=0", acc_ena); end
        total++; if (acc_a !== '0) begin bad++; $display("FAIL mrst_acc_a got=%0d want=0", acc_a); end
        total++; if (acc_a_d !== '0) begin bad++; $display("FAIL mrst_acc_a_d got=%0d want=0", acc_a_d); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL mrst_busy got=%0b want=0", busy); end
        total++; if (full !== 1'b0) begin bad++; $display("FAIL mrst_full got=%0b want=0", full); end
        total++; if (det !== 1'b0) begin bad++; $display("FAIL mrst_det got=%0b want=0", det); end
        total++; if (det_idx !== 16'd0) begin bad++; $display("FAIL mrst_det_idx got=%0d want=0", det_idx); end
        rst = 1'b1; in_stb = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            total++; if (det !== 1'b0) begin bad++; $display("FAIL mrst_late_det c=%0d got=%0b want=0", c, det); end
            total++; if (busy !== 1'b0) begin bad++; $display("FAIL mrst_late_busy c=%0d got=%0b want=0", c, busy); end
        end
        $display("mid-operation reset checked");
    endtask

    task automatic test_random();
        int thr_v;
        int e;
        for (int it = 0; it < 5; it++) begin
            if (it == 4) begin
                // Negative threshold with full-scale samples: every full
                // window is above it, exercising the signed compare.
                thr_v = -5;
                for (int i = 0; i < 128; i++) smp[i] = int'($urandom_range(0, 131071));
            end else begin
                thr_v = int'($urandom_range(1300, 1900));
                for (int i = 0; i < 128; i++) smp[i] = int'($urandom_range(0, 200));
            end
            e = find_det(64, thr_v);
            $display("random it=%0d thr=%0d expected det_idx=%0d", it, thr_v, e);
            do_start(thr_v);
            stream(64, e);
        end
    endtask

    initial begin
        test_reset();
        test_detect();
        test_no_detect();
        test_hit_qual();
        test_start_in_detect();
        test_abort();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
